// File: rtl/noc_config_pkg.sv
// -----------------------------------------------------------------------------
// noc_config_pkg
// Shared NoC configuration: the router configuration record, its default, the
// flow-control mode enumeration and the occupancy-counter width helper.
// -----------------------------------------------------------------------------
package noc_config_pkg;

    typedef enum logic {
        NOC_READY_FLOW_CONTROL,
        NOC_CREDIT_FLOW_CONTROL
    } noc_flow_control_mode;

    typedef struct packed {
        int unsigned virtual_channels;
        int unsigned input_fifo_depth;
        int unsigned flit_width;
    } noc_config;

    localparam noc_config NOC_DEFAULT_CONFIG = '{
        virtual_channels: 32'd4,
        input_fifo_depth: 32'd8,
        flit_width:       32'd64
    };

    // Width that can hold every value from 0 up to and including depth.
    function automatic int noc_vc_count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/noc_flit_if.sv
// -----------------------------------------------------------------------------
// noc_flit_if
// Valid/ready flit bundle with LANES independent lanes, each lane carrying its
// own payload.
//   valid  initiator -> target  per-lane flit present
//   ready  target -> initiator  per-lane flit accepted
//   flit   initiator -> target  per-lane payload
// -----------------------------------------------------------------------------
interface noc_flit_if #(
    parameter int LANES  = 1,
    parameter int FLIT_W = 32
);
    logic [LANES-1:0]             valid;
    logic [LANES-1:0]             ready;
    logic [LANES-1:0][FLIT_W-1:0] flit;

    modport initiator (output valid, output flit, input ready);
    modport target    (input valid, input flit, output ready);
endinterface

// File: rtl/noc_flit_if_splitter.sv
// -----------------------------------------------------------------------------
// noc_flit_if_splitter
// Breaks a multi-lane flit interface into plain per-lane signals and returns
// the per-lane ready back onto the interface.
//   in_if         target side of the multi-lane bundle
//   lane_valid_o  per-lane valid
//   lane_flit_o   per-lane payload
//   lane_ready_i  per-lane ready from the lane consumers
// -----------------------------------------------------------------------------
module noc_flit_if_splitter #(
    parameter int LANES  = 1,
    parameter int FLIT_W = 32
) (
    noc_flit_if.target                   in_if,
    output logic [LANES-1:0]             lane_valid_o,
    output logic [LANES-1:0][FLIT_W-1:0] lane_flit_o,
    input  logic [LANES-1:0]             lane_ready_i
);

    assign lane_valid_o = in_if.valid;
    assign lane_flit_o  = in_if.flit;
    assign in_if.ready  = lane_ready_i;

endmodule

// File: rtl/noc_vc_fifo_core.sv
// -----------------------------------------------------------------------------
// noc_vc_fifo_core
// Single virtual-channel FIFO: storage, wrap-at-DEPTH pointers, occupancy
// count, full/empty/almost-full flags, optional fall-through bypass, sticky
// overflow and registered credit-return pulse.
//   clk, rst_n       clock, asynchronous active-low reset
//   clear_i          synchronous flush
//   threshold_i      almost-full level, 0 disables
//   push_valid_i     incoming flit valid
//   push_flit_i      incoming flit payload
//   push_ready_o     incoming flit ready
//   pop_valid_o      head flit valid
//   pop_flit_o       head flit payload
//   pop_ready_i      downstream ready
//   empty_o, full_o, almost_full_o, count_o  occupancy status
//   credit_o         one-cycle pulse the cycle after each pop (credit mode)
//   overflow_o       sticky: push into a full FIFO was dropped
// -----------------------------------------------------------------------------
module noc_vc_fifo_core #(
    parameter int DEPTH       = 4,
    parameter int FLIT_W      = 32,
    parameter int CW          = 3,
    parameter bit CREDIT_MODE = 1'b0,
    parameter bit BYPASS      = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic [CW-1:0]     threshold_i,
    input  logic              push_valid_i,
    input  logic [FLIT_W-1:0] push_flit_i,
    output logic              push_ready_o,
    output logic              pop_valid_o,
    output logic [FLIT_W-1:0] pop_flit_o,
    input  logic              pop_ready_i,
    output logic              empty_o,
    output logic              full_o,
    output logic              almost_full_o,
    output logic [CW-1:0]     count_o,
    output logic              credit_o,
    output logic              overflow_o
);

    localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    // NOTE: the storage array has no reset; only pointers and count define
    // which entries are live, so resetting the data would only cost area.
    logic [FLIT_W-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          credit_q, credit_d;

    logic is_empty, is_full, in_ready;
    logic push, pop, bypass_hit, out_valid;
    logic write_en, read_en, overflow_evt;

    // DEPTH need not be a power of two, so wrap by compare rather than rollover.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    // NOTE: every signal written here gets a default at the top of the block,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        is_empty     = (count_q == '0);
        is_full      = (count_q == DEPTH_C);
        // Ready comes only from registered state: no path from pop_ready_i.
        in_ready     = CREDIT_MODE ? 1'b1 : !is_full;
        push         = push_valid_i & in_ready;
        bypass_hit   = BYPASS & is_empty & push;
        out_valid    = bypass_hit | !is_empty;
        pop          = out_valid & pop_ready_i;
        read_en      = pop & !is_empty;
        // A bypassed flit taken the same cycle never touches storage. At full,
        // a write is only possible when the head leaves in the same cycle.
        write_en     = push & !(bypass_hit & pop) & (!is_full | pop);
        overflow_evt = push & is_full & !pop;

        wr_ptr_d   = write_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = read_en  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d    = count_q;
        if (write_en && !read_en) begin
            count_d = count_q + 1'b1;
        end else if (!write_en && read_en) begin
            count_d = count_q - 1'b1;
        end
        overflow_d = overflow_q | overflow_evt;
        credit_d   = CREDIT_MODE & pop;

        // Flush wins over everything, including the credit of a same-cycle pop.
        if (clear_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            credit_d   = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            credit_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            credit_q   <= credit_d;
        end
    end

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem_q[wr_ptr_q] <= push_flit_i;
        end
    end

    assign push_ready_o  = in_ready;
    assign pop_valid_o   = out_valid;
    assign pop_flit_o    = bypass_hit ? push_flit_i : mem_q[rd_ptr_q];
    assign empty_o       = is_empty;
    assign full_o        = is_full;
    assign almost_full_o = (threshold_i != '0) && (count_q >= threshold_i);
    assign count_o       = count_q;
    assign credit_o      = credit_q;
    assign overflow_o    = overflow_q;

endmodule

// File: rtl/noc_vc_input_buffer.sv
// -----------------------------------------------------------------------------
// noc_vc_input_buffer
// Router input buffer: splits the incoming multi-lane flit interface by
// virtual channel into independent per-VC FIFOs and presents one output lane
// per VC to the route/arbitration stage.
//   clk, rst_n       clock, asynchronous active-low reset
//   i_clear          synchronous flush of all VCs
//   i_threshold      almost-full level (0 disables)
//   o_empty          per-VC empty
//   o_almost_full    per-VC count >= i_threshold
//   o_full           per-VC count == DEPTH
//   o_count          per-VC occupancy, VC0 in the LSBs
//   o_credit_return  per-VC pop credit pulse (credit mode only)
//   o_overflow       per-VC sticky dropped-push flag
//   flit_in_if       CHANNELS-lane input flit interface
//   flit_out_if      one single-lane output interface per VC
// -----------------------------------------------------------------------------
module noc_vc_input_buffer
    import noc_config_pkg::*;
#(
    parameter noc_config            CONFIG       = NOC_DEFAULT_CONFIG,
    parameter int                   DEPTH        = int'(CONFIG.input_fifo_depth),
    parameter noc_flow_control_mode FLOW_CONTROL = NOC_READY_FLOW_CONTROL,
    parameter bit                   BYPASS       = 1'b0,
    localparam int                  CHANNELS     = int'(CONFIG.virtual_channels),
    localparam int                  FLIT_W       = int'(CONFIG.flit_width),
    localparam int                  CW           = noc_vc_count_width(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clear,
    input  logic [CW-1:0]            i_threshold,
    output logic [CHANNELS-1:0]      o_empty,
    output logic [CHANNELS-1:0]      o_almost_full,
    output logic [CHANNELS-1:0]      o_full,
    output logic [CHANNELS*CW-1:0]   o_count,
    output logic [CHANNELS-1:0]      o_credit_return,
    output logic [CHANNELS-1:0]      o_overflow,
    noc_flit_if.target               flit_in_if,
    noc_flit_if.initiator            flit_out_if [CHANNELS]
);

    localparam bit CREDIT_MODE = (FLOW_CONTROL == NOC_CREDIT_FLOW_CONTROL);

    logic [CHANNELS-1:0]             lane_valid;
    logic [CHANNELS-1:0]             lane_ready;
    logic [CHANNELS-1:0][FLIT_W-1:0] lane_flit;

    noc_flit_if_splitter #(
        .LANES  (CHANNELS),
        .FLIT_W (FLIT_W)
    ) u_splitter (
        .in_if        (flit_in_if),
        .lane_valid_o (lane_valid),
        .lane_flit_o  (lane_flit),
        .lane_ready_i (lane_ready)
    );

    for (genvar g = 0; g < CHANNELS; g++) begin : g_vc
        logic [CW-1:0]     count_w;
        logic              out_valid_w;
        logic [FLIT_W-1:0] out_flit_w;

        noc_vc_fifo_core #(
            .DEPTH       (DEPTH),
            .FLIT_W      (FLIT_W),
            .CW          (CW),
            .CREDIT_MODE (CREDIT_MODE),
            .BYPASS      (BYPASS)
        ) u_core (
            .clk           (clk),
            .rst_n         (rst_n),
            .clear_i       (i_clear),
            .threshold_i   (i_threshold),
            .push_valid_i  (lane_valid[g]),
            .push_flit_i   (lane_flit[g]),
            .push_ready_o  (lane_ready[g]),
            .pop_valid_o   (out_valid_w),
            .pop_flit_o    (out_flit_w),
            .pop_ready_i   (flit_out_if[g].ready[0]),
            .empty_o       (o_empty[g]),
            .full_o        (o_full[g]),
            .almost_full_o (o_almost_full[g]),
            .count_o       (count_w),
            .credit_o      (o_credit_return[g]),
            .overflow_o    (o_overflow[g])
        );

        assign flit_out_if[g].valid   = out_valid_w;
        assign flit_out_if[g].flit    = out_flit_w;
        assign o_count[g*CW +: CW]    = count_w;
    end

endmodule

// File: tb/tb_noc_vc_input_buffer.sv
// -----------------------------------------------------------------------------
// tb_noc_vc_input_buffer
// Directed bench for two 2-VC, depth-6 buffers:
//   dut_a: ready flow control, no bypass
//   dut_b: credit flow control, bypass enabled
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_noc_vc_input_buffer;
    import noc_config_pkg::*;

    localparam noc_config TB_CFG = '{
        virtual_channels: 32'd2,
        input_fifo_depth: 32'd6,
        flit_width:       32'd16
    };

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // ---------------- dut_a signals ----------------
    logic            a_clear;
    logic [2:0]      a_thr;
    logic [1:0]      a_in_valid, a_in_ready, a_out_ready, a_out_valid;
    logic [1:0][15:0] a_in_flit, a_out_flit;
    logic [1:0]      a_empty, a_af, a_full, a_credit, a_ovf;
    logic [5:0]      a_count;

    // ---------------- dut_b signals ----------------
    logic            b_clear;
    logic [2:0]      b_thr;
    logic [1:0]      b_in_valid, b_in_ready, b_out_ready, b_out_valid;
    logic [1:0][15:0] b_in_flit, b_out_flit;
    logic [1:0]      b_empty, b_af, b_full, b_credit, b_ovf;
    logic [5:0]      b_count;

    noc_flit_if #(.LANES(2), .FLIT_W(16)) in_a ();
    noc_flit_if #(.LANES(1), .FLIT_W(16)) out_a [2] ();
    noc_flit_if #(.LANES(2), .FLIT_W(16)) in_b ();
    noc_flit_if #(.LANES(1), .FLIT_W(16)) out_b [2] ();

    assign in_a.valid        = a_in_valid;
    assign in_a.flit         = a_in_flit;
    assign a_in_ready        = in_a.ready;
    assign out_a[0].ready[0] = a_out_ready[0];
    assign out_a[1].ready[0] = a_out_ready[1];
    assign a_out_valid[0]    = out_a[0].valid[0];
    assign a_out_valid[1]    = out_a[1].valid[0];
    assign a_out_flit[0]     = out_a[0].flit[0];
    assign a_out_flit[1]     = out_a[1].flit[0];

    assign in_b.valid        = b_in_valid;
    assign in_b.flit         = b_in_flit;
    assign b_in_ready        = in_b.ready;
    assign out_b[0].ready[0] = b_out_ready[0];
    assign out_b[1].ready[0] = b_out_ready[1];
    assign b_out_valid[0]    = out_b[0].valid[0];
    assign b_out_valid[1]    = out_b[1].valid[0];
    assign b_out_flit[0]     = out_b[0].flit[0];
    assign b_out_flit[1]     = out_b[1].flit[0];

    noc_vc_input_buffer #(
        .CONFIG       (TB_CFG),
        .DEPTH        (6),
        .FLOW_CONTROL (NOC_READY_FLOW_CONTROL),
        .BYPASS       (1'b0)
    ) dut_a (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_clear         (a_clear),
        .i_threshold     (a_thr),
        .o_empty         (a_empty),
        .o_almost_full   (a_af),
        .o_full          (a_full),
        .o_count         (a_count),
        .o_credit_return (a_credit),
        .o_overflow      (a_ovf),
        .flit_in_if      (in_a),
        .flit_out_if     (out_a)
    );

    noc_vc_input_buffer #(
        .CONFIG       (TB_CFG),
        .DEPTH        (6),
        .FLOW_CONTROL (NOC_CREDIT_FLOW_CONTROL),
        .BYPASS       (1'b1)
    ) dut_b (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_clear         (b_clear),
        .i_threshold     (b_thr),
        .o_empty         (b_empty),
        .o_almost_full   (b_af),
        .o_full          (b_full),
        .o_count         (b_count),
        .o_credit_return (b_credit),
        .o_overflow      (b_ovf),
        .flit_in_if      (in_b),
        .flit_out_if     (out_b)
    );

    // Advance to just after the next rising edge (where inputs are driven).
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge of the current cycle (where outputs are sampled).
    task automatic settle();
        @(negedge clk);
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset();
        #3;
        tests_run++;
        if (a_empty !== 2'b11 || a_full !== 2'b00 || a_count !== 6'd0 || a_af !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_a_status: empty=%b full=%b count=%h af=%b, expected 11 00 00 00",
                     a_empty, a_full, a_count, a_af);
        end
        tests_run++;
        if (a_credit !== 2'b00 || a_ovf !== 2'b00 || a_out_valid !== 2'b00 || a_in_ready !== 2'b11) begin
            tests_failed++;
            $display("FAIL reset_a_flow: credit=%b ovf=%b out_valid=%b in_ready=%b, expected 00 00 00 11",
                     a_credit, a_ovf, a_out_valid, a_in_ready);
        end
        tests_run++;
        if (b_empty !== 2'b11 || b_count !== 6'd0 || b_credit !== 2'b00 || b_ovf !== 2'b00 ||
            b_out_valid !== 2'b00 || b_in_ready !== 2'b11) begin
            tests_failed++;
            $display("FAIL reset_b: empty=%b count=%h credit=%b ovf=%b out_valid=%b in_ready=%b",
                     b_empty, b_count, b_credit, b_ovf, b_out_valid, b_in_ready);
        end
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    // ---------------------------------------------------------------------
    task automatic test_fill_drain();
        a_out_ready = 2'b00;
        for (int k = 0; k < 6; k++) begin
            a_in_valid   = 2'b01;
            a_in_flit[0] = 16'hA000 + 16'(k);
            settle();
            // Without bypass the first flit appears only the cycle after its push.
            tests_run++;
            if (a_out_valid[0] !== (k != 0) || (k != 0 && a_out_flit[0] !== 16'hA000)) begin
                tests_failed++;
                $display("FAIL fill_head k=%0d: valid=%b flit=%h, expected valid=%b flit=a000",
                         k, a_out_valid[0], a_out_flit[0], (k != 0));
            end
            cycle();
        end
        a_in_valid = 2'b00;
        settle();
        tests_run++;
        if (a_count[2:0] !== 3'd6 || a_full !== 2'b01 || a_in_ready !== 2'b10 || a_empty !== 2'b10) begin
            tests_failed++;
            $display("FAIL fill_full: count0=%0d full=%b in_ready=%b empty=%b, expected 6 01 10 10",
                     a_count[2:0], a_full, a_in_ready, a_empty);
        end
        cycle();

        // VC1 keeps flowing while VC0 is full and blocked.
        a_in_valid   = 2'b10;
        a_in_flit[1] = 16'hC001;
        settle();
        tests_run++;
        if (a_out_valid[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL vc1_same_cycle: valid=%b, expected 0", a_out_valid[1]);
        end
        cycle();
        a_in_valid = 2'b00;
        settle();
        tests_run++;
        if (a_out_valid[1] !== 1'b1 || a_out_flit[1] !== 16'hC001 || a_count[5:3] !== 3'd1) begin
            tests_failed++;
            $display("FAIL vc1_independent: valid=%b flit=%h count1=%0d, expected 1 c001 1",
                     a_out_valid[1], a_out_flit[1], a_count[5:3]);
        end
        cycle();
        a_out_ready = 2'b10;
        cycle();

        // Push and pop on full VC0 in the same cycle: the push is refused.
        a_in_valid   = 2'b01;
        a_in_flit[0] = 16'hBAD0;
        a_out_ready  = 2'b01;
        settle();
        tests_run++;
        if (a_out_valid[0] !== 1'b1 || a_out_flit[0] !== 16'hA000) begin
            tests_failed++;
            $display("FAIL drain_0: valid=%b flit=%h, expected 1 a000", a_out_valid[0], a_out_flit[0]);
        end
        cycle();
        a_in_valid = 2'b00;
        for (int k = 1; k < 6; k++) begin
            settle();
            tests_run++;
            if (a_out_valid[0] !== 1'b1 || a_out_flit[0] !== 16'hA000 + 16'(k) || a_credit !== 2'b00) begin
                tests_failed++;
                $display("FAIL drain_%0d: valid=%b flit=%h credit=%b, expected 1 %h 00",
                         k, a_out_valid[0], a_out_flit[0], a_credit, 16'hA000 + 16'(k));
            end
            cycle();
        end
        a_out_ready = 2'b00;
        settle();
        tests_run++;
        if (a_count !== 6'd0 || a_empty !== 2'b11 || a_credit !== 2'b00 || a_ovf !== 2'b00) begin
            tests_failed++;
            $display("FAIL drain_end: count=%h empty=%b credit=%b ovf=%b, expected 00 11 00 00",
                     a_count, a_empty, a_credit, a_ovf);
        end
        cycle();
    endtask

    // ---------------------------------------------------------------------
    task automatic test_threshold();
        a_thr       = 3'd4;
        a_out_ready = 2'b00;
        for (int k = 0; k < 3; k++) begin
            a_in_valid   = 2'b01;
            a_in_flit[0] = 16'h1000 + 16'(k);
            cycle();
        end
        a_in_valid = 2'b00;
        settle();
        tests_run++;
        if (a_count[2:0] !== 3'd3 || a_af[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL thr_below: count0=%0d af=%b, expected 3 0", a_count[2:0], a_af[0]);
        end
        cycle();
        a_in_valid   = 2'b01;
        a_in_flit[0] = 16'h1003;
        cycle();
        a_in_valid = 2'b00;
        settle();
        tests_run++;
        if (a_count[2:0] !== 3'd4 || a_af !== 2'b01) begin
            tests_failed++;
            $display("FAIL thr_at: count0=%0d af=%b, expected 4 01", a_count[2:0], a_af);
        end
        a_thr = 3'd0;
        #1;
        tests_run++;
        if (a_af !== 2'b00) begin
            tests_failed++;
            $display("FAIL thr_zero: af=%b, expected 00", a_af);
        end
        a_thr = 3'd7;
        #1;
        tests_run++;
        if (a_af !== 2'b00) begin
            tests_failed++;
            $display("FAIL thr_above_depth: af=%b, expected 00", a_af);
        end
        a_thr = 3'd4;
        cycle();
        a_clear = 1'b1;
        cycle();
        a_clear = 1'b0;
        settle();
        tests_run++;
        if (a_count !== 6'd0 || a_empty !== 2'b11 || a_out_valid !== 2'b00) begin
            tests_failed++;
            $display("FAIL thr_clear: count=%h empty=%b out_valid=%b, expected 00 11 00",
                     a_count, a_empty, a_out_valid);
        end
        cycle();
    endtask

    // ---------------------------------------------------------------------
    task automatic test_wrap();
        int sent = 0;
        int rcvd = 0;
        int cyc = 0;
        int max_cnt = 0;
        while (rcvd < 20 && cyc < 200) begin
            a_in_valid[0]  = (sent < 20);
            a_in_flit[0]   = 16'h5000 + 16'(sent);
            a_out_ready[0] = (((cyc / 3) % 2) == 0);
            settle();
            if (a_out_valid[0] && a_out_ready[0]) begin
                tests_run++;
                if (a_out_flit[0] !== 16'h5000 + 16'(rcvd)) begin
                    tests_failed++;
                    $display("FAIL wrap_order #%0d: flit=%h, expected %h",
                             rcvd, a_out_flit[0], 16'h5000 + 16'(rcvd));
                end
                rcvd++;
            end
            if (a_in_valid[0] && a_in_ready[0]) sent++;
            if (int'(a_count[2:0]) > max_cnt) max_cnt = int'(a_count[2:0]);
            cycle();
            cyc++;
        end
        a_in_valid  = 2'b00;
        a_out_ready = 2'b00;
        tests_run++;
        if (rcvd != 20) begin
            tests_failed++;
            $display("FAIL wrap_timeout: received %0d flits, expected 20", rcvd);
        end
        tests_run++;
        if (max_cnt > 6) begin
            tests_failed++;
            $display("FAIL wrap_max_count: peak %0d, expected at most 6", max_cnt);
        end
        settle();
        tests_run++;
        if (a_count !== 6'd0 || a_empty !== 2'b11) begin
            tests_failed++;
            $display("FAIL wrap_end: count=%h empty=%b, expected 00 11", a_count, a_empty);
        end
        cycle();
    endtask

    // ---------------------------------------------------------------------
    task automatic test_credit();
        b_out_ready = 2'b00;
        for (int k = 0; k < 6; k++) begin
            b_in_valid   = 2'b01;
            b_in_flit[0] = 16'hD000 + 16'(k);
            cycle();
        end
        b_in_valid = 2'b00;
        settle();
        tests_run++;
        if (b_count[2:0] !== 3'd6 || b_full !== 2'b01 || b_in_ready !== 2'b11 || b_out_flit[0] !== 16'hD000) begin
            tests_failed++;
            $display("FAIL credit_fill: count0=%0d full=%b in_ready=%b head=%h, expected 6 01 11 d000",
                     b_count[2:0], b_full, b_in_ready, b_out_flit[0]);
        end
        cycle();

        // Push and pop at full: accepted, count stays at 6.
        b_in_valid   = 2'b01;
        b_in_flit[0] = 16'hD006;
        b_out_ready  = 2'b01;
        cycle();
        b_in_valid  = 2'b00;
        b_out_ready = 2'b00;
        settle();
        tests_run++;
        if (b_count[2:0] !== 3'd6 || b_credit !== 2'b01 || b_ovf !== 2'b00) begin
            tests_failed++;
            $display("FAIL credit_full_pushpop: count0=%0d credit=%b ovf=%b, expected 6 01 00",
                     b_count[2:0], b_credit, b_ovf);
        end
        cycle();
        settle();
        tests_run++;
        if (b_credit !== 2'b00) begin
            tests_failed++;
            $display("FAIL credit_single_pulse: credit=%b, expected 00", b_credit);
        end
        cycle();

        // Push at full without a pop: dropped, overflow sticks.
        b_in_valid   = 2'b01;
        b_in_flit[0] = 16'hDEAD;
        cycle();
        b_in_valid = 2'b00;
        settle();
        tests_run++;
        if (b_count[2:0] !== 3'd6 || b_ovf !== 2'b01 || b_credit !== 2'b00) begin
            tests_failed++;
            $display("FAIL credit_overflow: count0=%0d ovf=%b credit=%b, expected 6 01 00",
                     b_count[2:0], b_ovf, b_credit);
        end
        cycle();
        cycle();
        settle();
        tests_run++;
        if (b_ovf !== 2'b01) begin
            tests_failed++;
            $display("FAIL credit_overflow_sticky: ovf=%b, expected 01", b_ovf);
        end
        cycle();

        // Storage must hold d001..d006; the dropped flit never appears.
        b_out_ready = 2'b01;
        for (int k = 0; k < 6; k++) begin
            settle();
            tests_run++;
            if (b_out_valid[0] !== 1'b1 || b_out_flit[0] !== 16'hD001 + 16'(k) ||
                b_credit !== ((k == 0) ? 2'b00 : 2'b01)) begin
                tests_failed++;
                $display("FAIL credit_drain_%0d: valid=%b flit=%h credit=%b, expected 1 %h %b",
                         k, b_out_valid[0], b_out_flit[0], b_credit, 16'hD001 + 16'(k),
                         (k == 0) ? 2'b00 : 2'b01);
            end
            cycle();
        end
        b_out_ready = 2'b00;
        settle();
        tests_run++;
        if (b_credit !== 2'b01 || b_count !== 6'd0 || b_empty !== 2'b11 || b_ovf !== 2'b01) begin
            tests_failed++;
            $display("FAIL credit_drain_end: credit=%b count=%h empty=%b ovf=%b, expected 01 00 11 01",
                     b_credit, b_count, b_empty, b_ovf);
        end
        cycle();
        b_clear = 1'b1;
        cycle();
        b_clear = 1'b0;
        settle();
        tests_run++;
        if (b_ovf !== 2'b00) begin
            tests_failed++;
            $display("FAIL credit_ovf_clear: ovf=%b, expected 00", b_ovf);
        end
        cycle();
    endtask

    // ---------------------------------------------------------------------
    task automatic test_bypass();
        b_out_ready  = 2'b10;
        b_in_valid   = 2'b10;
        b_in_flit[1] = 16'hE111;
        settle();
        tests_run++;
        if (b_out_valid[1] !== 1'b1 || b_out_flit[1] !== 16'hE111) begin
            tests_failed++;
            $display("FAIL bypass_same_cycle: valid=%b flit=%h, expected 1 e111", b_out_valid[1], b_out_flit[1]);
        end
        cycle();
        b_in_valid  = 2'b00;
        b_out_ready = 2'b00;
        settle();
        tests_run++;
        if (b_count[5:3] !== 3'd0 || b_empty[1] !== 1'b1 || b_credit !== 2'b10) begin
            tests_failed++;
            $display("FAIL bypass_not_stored: count1=%0d empty1=%b credit=%b, expected 0 1 10",
                     b_count[5:3], b_empty[1], b_credit);
        end
        cycle();
        settle();
        tests_run++;
        if (b_credit !== 2'b00) begin
            tests_failed++;
            $display("FAIL bypass_credit_pulse: credit=%b, expected 00", b_credit);
        end
        cycle();

        // Bypassed but not taken: the flit is stored.
        b_in_valid   = 2'b10;
        b_in_flit[1] = 16'hE222;
        settle();
        tests_run++;
        if (b_out_valid[1] !== 1'b1 || b_out_flit[1] !== 16'hE222) begin
            tests_failed++;
            $display("FAIL bypass_stall_view: valid=%b flit=%h, expected 1 e222", b_out_valid[1], b_out_flit[1]);
        end
        cycle();
        b_in_valid = 2'b00;
        settle();
        tests_run++;
        if (b_count[5:3] !== 3'd1 || b_out_valid[1] !== 1'b1 || b_out_flit[1] !== 16'hE222 || b_credit !== 2'b00) begin
            tests_failed++;
            $display("FAIL bypass_stored: count1=%0d valid=%b flit=%h credit=%b, expected 1 1 e222 00",
                     b_count[5:3], b_out_valid[1], b_out_flit[1], b_credit);
        end
        cycle();
        b_out_ready = 2'b10;
        cycle();
        b_out_ready = 2'b00;
        settle();
        tests_run++;
        if (b_count !== 6'd0 || b_credit !== 2'b10) begin
            tests_failed++;
            $display("FAIL bypass_drain: count=%h credit=%b, expected 00 10", b_count, b_credit);
        end
        cycle();
    endtask

    // ---------------------------------------------------------------------
    task automatic test_clear();
        b_out_ready = 2'b00;
        for (int k = 0; k < 5; k++) begin
            b_in_valid   = 2'b01;
            b_in_flit[0] = 16'h7000 + 16'(k);
            cycle();
        end
        b_in_valid = 2'b00;
        settle();
        tests_run++;
        if (b_count[2:0] !== 3'd5) begin
            tests_failed++;
            $display("FAIL clear_setup: count0=%0d, expected 5", b_count[2:0]);
        end
        cycle();
        b_in_valid   = 2'b01;
        b_in_flit[0] = 16'h7005;
        b_out_ready  = 2'b01;
        b_clear      = 1'b1;
        cycle();
        b_in_valid  = 2'b00;
        b_out_ready = 2'b00;
        b_clear     = 1'b0;
        settle();
        tests_run++;
        if (b_count !== 6'd0 || b_empty !== 2'b11 || b_credit !== 2'b00 || b_out_valid !== 2'b00) begin
            tests_failed++;
            $display("FAIL clear_result: count=%h empty=%b credit=%b out_valid=%b, expected 00 11 00 00",
                     b_count, b_empty, b_credit, b_out_valid);
        end
        cycle();
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset_mid();
        a_out_ready = 2'b00;
        for (int k = 0; k < 3; k++) begin
            a_in_valid   = 2'b01;
            a_in_flit[0] = 16'h9000 + 16'(k);
            cycle();
        end
        // Input still valid: reset lands mid-stream, between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (a_count !== 6'd0 || a_empty !== 2'b11 || a_full !== 2'b00 || a_af !== 2'b00 ||
            a_ovf !== 2'b00 || a_credit !== 2'b00 || a_out_valid !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_mid: count=%h empty=%b full=%b af=%b ovf=%b credit=%b out_valid=%b",
                     a_count, a_empty, a_full, a_af, a_ovf, a_credit, a_out_valid);
        end
        cycle();
        a_in_valid = 2'b00;
        rst_n = 1'b1;
        cycle();
        settle();
        tests_run++;
        if (a_count !== 6'd0 || a_empty !== 2'b11) begin
            tests_failed++;
            $display("FAIL reset_mid_release: count=%h empty=%b, expected 00 11", a_count, a_empty);
        end
        cycle();
    endtask

    // ---------------------------------------------------------------------
    initial begin
        a_clear = 1'b0; a_thr = 3'd4; a_in_valid = 2'b00; a_in_flit = '0; a_out_ready = 2'b00;
        b_clear = 1'b0; b_thr = 3'd4; b_in_valid = 2'b00; b_in_flit = '0; b_out_ready = 2'b00;
        test_reset();
        test_fill_drain();
        test_threshold();
        test_wrap();
        test_credit();
        test_bypass();
        test_clear();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
